bcd_result_converter: RTL and testbench
=======================================

Name: bcd_result_converter

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the 4x4 BCD-digit multiplier.
- Accepts the multiplier's 8-bit binary product (0..81 for valid digits; any 0..255 accepted) and converts it by iterative shift-and-add-3 (double dabble), one bit per clock.
- Presents packed BCD digits plus leading-zero blanking flags to the seven-segment display driver.
- Uses a valid/ready handshake on both sides; the result register holds the last conversion for the display.

Parameters:
- WIDTH, 8, binary input width in bits.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; smaller values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  bin is valid
- in_ready  output  1  converter can accept bin
- bin  input  WIDTH  binary value to convert (multiplier product y)
- out_valid  output  1  bcd/blank hold a fresh, unconsumed result
- out_ready  input  1  consumer takes the result
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
- blank  output  DIGITS  1 = digit is a leading zero; blank[0] is always 0
- busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- Reset (async assert, applied immediately; released synchronously to clk by the system):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - bcd = 0, blank = {DIGITS-1 ones, 0} (displays "0").
  - Internal working registers cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. When in_valid is high at an edge, load shift_reg = bin, work_bcd = 0, cnt = 0, go to SHIFT. No accept otherwise.
  - SHIFT: in_ready = 0, busy = 1. Each edge performs one step:
    - Every 4-bit nibble of work_bcd that is >= 5 gets +3.
    - Then {work_bcd, shift_reg} shifts left by 1.
    - cnt increments.
    - On the edge where cnt reaches WIDTH-1, the final shifted work_bcd is written to bcd, blank is recomputed, out_valid is set to 1, and the FSM goes to DONE.
  - DONE: out_valid = 1, in_ready = 0. bcd and blank are stable. When out_ready is high at an edge, out_valid is cleared and the FSM goes to IDLE.
- Latency:
  - Accept at edge E0; out_valid is high after edge E0+WIDTH (exactly WIDTH SHIFT cycles).
  - Minimum accept-to-accept spacing is WIDTH+2 cycles with out_ready held high.
- Handshake rules:
  - in_ready is a function of state only.
  - bin is sampled only at the accept edge; later changes of bin are ignored.
  - in_valid is ignored in SHIFT and DONE. An upstream holding in_valid high is accepted once the FSM returns to IDLE.
  - out_ready is ignored outside DONE.
- Output hold:
  - bcd and blank change only at the completion edge or at reset.
  - Between results they keep the previous value, with out_valid low.
- blank rule:
  - blank[k] = 1 iff digit k and every higher digit are zero, for k >= 1.
  - blank[0] = 0.
  - Example: bcd 0x007 gives blank = 3'b110.
- Width rules:
  - Add-3 correction is applied per nibble, with no carry between nibbles.
  - Digits never exceed 9 at completion.
  - No overflow is possible under the DIGITS constraint.
- Boundary cases:
  - bin = 0 converts normally in WIDTH cycles; result 0x000, blank 110.
  - bin = 2^WIDTH - 1 (255) gives 0x255.
  - Reset mid-SHIFT or in DONE aborts: reset values apply and the partial result is discarded.
  - in_valid and out_ready high in the same DONE cycle: only the release happens. The accept occurs the next cycle, in IDLE.

Test Plan:
- Reset, then bin = 81 (0x51) with in_valid pulsed one cycle -> in_ready falls, busy high for 8 cycles; at the 8th edge bcd = 0x081, blank = 3'b100, out_valid = 1.
- bin = 0 -> after 8 cycles bcd = 0x000, blank = 3'b110; bin = 255 -> bcd = 0x255, blank = 3'b000.
- Backpressure: result 0x036 (bin = 36) with out_ready low for 5 cycles -> out_valid and bcd held steady. A new in_valid with bin = 9 during the hold is not accepted (in_ready = 0). It is accepted one cycle after out_ready is asserted and gives 0x009, blank 110.
- Back-to-back: in_valid held high, bins 49 then 64, out_ready high -> two results 0x049 then 0x064, accept edges exactly 10 cycles apart.
- Reset mid-operation: assert rst 4 cycles into converting bin = 72 -> outputs immediately at reset values (out_valid = 0, bcd = 0, in_ready = 1). A fresh conversion of 72 afterwards gives 0x072.
- Exhaustive sweep of bin 0..255 with random out_ready stalls -> every bcd equals the decimal value, and blank matches the leading-zero rule.

Source files
------------

// File: rtl/bcd_result_converter.sv
// bcd_result_converter: sequential binary-to-BCD (double dabble), one bit per clock, with valid/ready on both sides.
module bcd_result_converter #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK0 = ~DIGITS'(1);
  state_t state;
  logic [WIDTH-1:0] shift_reg;
  logic [4*DIGITS-1:0] work_bcd, adj, nxt;
  logic [CW-1:0] cnt;
  logic [DIGITS-1:0] nb;
  logic z;
  assign in_ready = state == IDLE;
  assign busy = state == SHIFT;
  assign out_valid = state == DONE;
  // nb flags digits that are zero along with every digit above them
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = work_bcd[4*k+:4] >= 4'd5 ? work_bcd[4*k+:4] + 4'd3 : work_bcd[4*k+:4];
    nxt = {adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
    z = 1'b1;
    nb = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      z = z & (nxt[4*k+:4] == 4'd0);
      nb[k] = z;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shift_reg <= '0;
      work_bcd <= '0;
      cnt <= '0;
      bcd <= '0;
      blank <= BLANK0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shift_reg <= bin;
          work_bcd <= '0;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          work_bcd <= nxt;
          shift_reg <= shift_reg << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd <= nxt;
            blank <= nb;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_result_converter.sv
// tb_bcd_result_converter: directed and sweep checks of the binary-to-BCD converter.
module tb_bcd_result_converter;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] bin = 0;
  logic in_ready, out_valid, busy;
  logic [11:0] bcd;
  logic [2:0] blank;
  int checks = 0, fails = 0;

  bcd_result_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .blank(blank), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic start(input logic [7:0] b);
    @(negedge clk);
    bin = b;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) break;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic release_out();
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bcd !== 12'h000) begin fails++; $display("FAIL reset_bcd got %h want 000", bcd); end
    checks++; if (blank !== 3'b110) begin fails++; $display("FAIL reset_blank got %b want 110", blank); end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_basic();
    int cyc;
    start(8'd81);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready got %b want 0", in_ready); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(cyc);
    checks++; if (cyc != 8) begin fails++; $display("FAIL basic_latency got %0d want 8", cyc); end
    checks++; if (bcd !== 12'h081) begin fails++; $display("FAIL basic_bcd got %h want 081", bcd); end
    checks++; if (blank !== 3'b100) begin fails++; $display("FAIL basic_blank got %b want 100", blank); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b want 0", busy); end
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    checks++; if (bcd !== 12'h081) begin fails++; $display("FAIL basic_hold got %h want 081", bcd); end
  endtask

  task automatic test_bounds();
    int cyc;
    start(8'd0);
    wait_done(cyc);
    checks++; if (cyc != 8) begin fails++; $display("FAIL zero_latency got %0d want 8", cyc); end
    checks++; if (bcd !== 12'h000 || blank !== 3'b110) begin fails++; $display("FAIL zero_result got %h/%b want 000/110", bcd, blank); end
    release_out();
    start(8'd255);
    wait_done(cyc);
    checks++; if (bcd !== 12'h255 || blank !== 3'b000) begin fails++; $display("FAIL max_result got %h/%b want 255/000", bcd, blank); end
    release_out();
  endtask

  task automatic test_backpressure();
    int cyc;
    start(8'd36);
    wait_done(cyc);
    checks++; if (bcd !== 12'h036 || blank !== 3'b100) begin fails++; $display("FAIL bp_result got %h/%b want 036/100", bcd, blank); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bin = 8'd9; in_valid = 1; end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || bcd !== 12'h036 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got ov=%b bcd=%h ir=%b want 1/036/0", i, out_valid, bcd, in_ready); end
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    @(posedge clk);
    #1 in_valid = 0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_accept got busy=%b want 1", busy); end
    wait_done(cyc);
    checks++; if (cyc != 8 || bcd !== 12'h009 || blank !== 3'b110) begin fails++; $display("FAIL bp_second got cyc=%0d %h/%b want 8 009/110", cyc, bcd, blank); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int acc[2];
    logic [11:0] res[2];
    int na = 0, nr = 0;
    logic a;
    @(negedge clk);
    bin = 8'd49;
    in_valid = 1;
    out_ready = 1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      a = in_ready;
      @(posedge clk);
      #1;
      if (a && na < 2) begin
        acc[na] = cyc;
        na++;
        if (na == 1) bin = 8'd64; else in_valid = 0;
      end
      if (out_valid && nr < 2) begin res[nr] = bcd; nr++; end
      if (nr == 2) break;
    end
    @(posedge clk);
    #1 out_ready = 0;
    in_valid = 0;
    checks++; if (na != 2 || nr != 2) begin fails++; $display("FAIL b2b_count got acc=%0d res=%0d want 2/2", na, nr); end
    else begin
      checks++; if (acc[1] - acc[0] != 10) begin fails++; $display("FAIL b2b_spacing got %0d want 10", acc[1] - acc[0]); end
      checks++; if (res[0] !== 12'h049) begin fails++; $display("FAIL b2b_first got %h want 049", res[0]); end
      checks++; if (res[1] !== 12'h064) begin fails++; $display("FAIL b2b_second got %h want 064", res[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start(8'd72);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    checks++; if (bcd !== 12'h000 || blank !== 3'b110) begin fails++; $display("FAIL rstmid_data got %h/%b want 000/110", bcd, blank); end
    @(negedge clk) rst = 0;
    start(8'd72);
    wait_done(cyc);
    checks++; if (cyc != 8 || bcd !== 12'h072 || blank !== 3'b100) begin fails++; $display("FAIL rstmid_after got cyc=%0d %h/%b want 8 072/100", cyc, bcd, blank); end
    release_out();
  endtask

  task automatic test_sweep();
    int cyc, h, t, u;
    logic [11:0] eb;
    logic [2:0] ebl;
    for (int b = 0; b < 256; b++) begin
      h = b / 100;
      t = (b / 10) % 10;
      u = b % 10;
      eb = {h[3:0], t[3:0], u[3:0]};
      ebl = {h == 0, h == 0 && t == 0, 1'b0};
      start(b[7:0]);
      wait_done(cyc);
      checks++; if (cyc != 8 || bcd !== eb || blank !== ebl) begin fails++; $display("FAIL sweep_%0d got cyc=%0d %h/%b want 8 %h/%b", b, cyc, bcd, blank, eb, ebl); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || bcd !== eb) begin fails++; $display("FAIL sweep_hold_%0d got ov=%b %h want 1 %h", b, out_valid, bcd, eb); end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
